// File: rtl/instr_mem_fetch_if.sv
// Fetch/load bus between the PC stage, the program loader, the instruction memory and decode.
interface instr_mem_fetch_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                  Load_en;
  logic [ADDR_WIDTH-1:0] Load_addr;
  logic [DATA_WIDTH-1:0] Load_data;
  logic                  Req_valid;
  logic [ADDR_WIDTH-1:0] Address;
  logic                  Req_ready;
  logic                  Flush;
  logic [DATA_WIDTH-1:0] Instruction;
  logic                  Instr_valid;
  logic                  Instr_ready;
  logic                  Addr_fault;

  modport master (
    output Load_en, Load_addr, Load_data, Req_valid, Address, Flush, Instr_ready,
    input  Req_ready, Instruction, Instr_valid, Addr_fault
  );

  modport slave (
    input  Load_en, Load_addr, Load_data, Req_valid, Address, Flush, Instr_ready,
    output Req_ready, Instruction, Instr_valid, Addr_fault
  );
endinterface

// File: rtl/instr_mem_fetch.sv
// Instruction memory with program-load port, 1-cycle registered fetch, back-pressure hold,
// flush for branch redirects and out-of-range address flagging.
module instr_mem_fetch #(
  parameter int                  DATA_WIDTH = 16,
  parameter int                  ADDR_WIDTH = 8,
  parameter int                  DEPTH      = 256,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD = '0
) (
  input  logic               Clk,
  input  logic               Reset_n,
  instr_mem_fetch_if.slave   bus
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_WIDTH does not wrap to zero.
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] instr, instr_nxt;
  logic                  fault, fault_nxt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic fetch_in_range, load_in_range, accept;

  assign fetch_in_range = {1'b0, bus.Address}   < DEPTH_EXT;
  assign load_in_range  = {1'b0, bus.Load_addr} < DEPTH_EXT;

  assign bus.Req_ready   = Reset_n & ~bus.Load_en & ((state == EMPTY) | bus.Instr_ready);
  assign accept          = bus.Req_valid & bus.Req_ready;
  assign bus.Instruction = instr;
  assign bus.Instr_valid = (state == FULL);
  assign bus.Addr_fault  = fault;

  always_ff @(posedge Clk) begin
    if (bus.Load_en && load_in_range)
      mem[bus.Load_addr[IW-1:0]] <= bus.Load_data;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= EMPTY;
      instr <= NOP_WORD;
      fault <= 1'b0;
    end else begin
      state <= state_nxt;
      instr <= instr_nxt;
      fault <= fault_nxt;
    end
  end

  // Flush beats accept; a drain keeps the last word but drops the fault flag.
  always_comb begin
    state_nxt = state;
    instr_nxt = instr;
    fault_nxt = fault;
    if (bus.Flush) begin
      state_nxt = EMPTY;
      instr_nxt = NOP_WORD;
      fault_nxt = 1'b0;
    end else if (accept) begin
      state_nxt = FULL;
      instr_nxt = fetch_in_range ? mem[bus.Address[IW-1:0]] : NOP_WORD;
      fault_nxt = ~fetch_in_range;
    end else if (state == FULL && bus.Instr_ready) begin
      state_nxt = EMPTY;
      fault_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Directed table-driven bench for instr_mem_fetch (DEPTH=200 so the fault path is reachable).
module tb_instr_mem_fetch;
  localparam int DW = 16;
  localparam int AW = 8;

  logic Clk = 1'b0;
  logic Reset_n;
  int   errors = 0;
  int   checks = 0;

  instr_mem_fetch_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  instr_mem_fetch #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(200), .NOP_WORD(16'h0000)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic          rst_n;
    logic          ld;
    logic [AW-1:0] la;
    logic [DW-1:0] ldat;
    logic          rv;
    logic [AW-1:0] addr;
    logic          fl;
    logic          ir;
    logic          exp_rdy;
    logic          exp_v;
    logic [DW-1:0] exp_ins;
    logic          exp_f;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst_n, logic ld, logic [AW-1:0] la, logic [DW-1:0] ldat,
                              logic rv, logic [AW-1:0] addr, logic fl, logic ir,
                              logic exp_rdy, logic exp_v, logic [DW-1:0] exp_ins, logic exp_f);
    vec_t v;
    v.rst_n = rst_n; v.ld = ld; v.la = la; v.ldat = ldat;
    v.rv = rv; v.addr = addr; v.fl = fl; v.ir = ir;
    v.exp_rdy = exp_rdy; v.exp_v = exp_v; v.exp_ins = exp_ins; v.exp_f = exp_f;
    return v;
  endfunction

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle: Req_ready checked before the edge, registered outputs #1 after it.
  task automatic step(string tag, vec_t v);
    Reset_n         = v.rst_n;
    bus.Load_en     = v.ld;
    bus.Load_addr   = v.la;
    bus.Load_data   = v.ldat;
    bus.Req_valid   = v.rv;
    bus.Address     = v.addr;
    bus.Flush       = v.fl;
    bus.Instr_ready = v.ir;
    #1;
    check({tag, ".Req_ready"}, DW'(bus.Req_ready), DW'(v.exp_rdy));
    @(posedge Clk);
    #1;
    check({tag, ".Instr_valid"}, DW'(bus.Instr_valid), DW'(v.exp_v));
    check({tag, ".Instruction"}, bus.Instruction, v.exp_ins);
    check({tag, ".Addr_fault"},  DW'(bus.Addr_fault), DW'(v.exp_f));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rst ld la   ldat      rv addr fl ir   rdy v  ins       f
    tbl.push_back(mk(0, 0, 0,   16'h0,    0, 0,   0, 0,  0, 0, 16'h0000, 0)); // reset
    tbl.push_back(mk(1, 1, 0,   16'h1111, 0, 0,   0, 1,  0, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 1, 1,   16'h2222, 0, 0,   0, 1,  0, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 1, 2,   16'h3333, 0, 0,   0, 1,  0, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 1, 3,   16'h4444, 0, 0,   0, 1,  0, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 0, 0,   16'h0,    1, 0,   0, 1,  1, 1, 16'h1111, 0)); // stream
    tbl.push_back(mk(1, 0, 0,   16'h0,    1, 1,   0, 1,  1, 1, 16'h2222, 0));
    tbl.push_back(mk(1, 0, 0,   16'h0,    1, 2,   0, 1,  1, 1, 16'h3333, 0));
    tbl.push_back(mk(1, 0, 0,   16'h0,    1, 3,   0, 1,  1, 1, 16'h4444, 0));
    tbl.push_back(mk(1, 0, 0,   16'h0,    1, 2,   0, 1,  1, 1, 16'h3333, 0)); // back-pressure
    tbl.push_back(mk(1, 0, 0,   16'h0,    1, 3,   0, 0,  0, 1, 16'h3333, 0));
    tbl.push_back(mk(1, 0, 0,   16'h0,    1, 3,   0, 0,  0, 1, 16'h3333, 0));
    tbl.push_back(mk(1, 0, 0,   16'h0,    1, 3,   0, 0,  0, 1, 16'h3333, 0));
    tbl.push_back(mk(1, 0, 0,   16'h0,    1, 3,   0, 1,  1, 1, 16'h4444, 0));
    tbl.push_back(mk(1, 0, 0,   16'h0,    0, 0,   0, 1,  1, 0, 16'h4444, 0)); // drain only
    tbl.push_back(mk(1, 0, 0,   16'h0,    1, 210, 0, 1,  1, 1, 16'h0000, 1)); // fault
    tbl.push_back(mk(1, 0, 0,   16'h0,    0, 0,   0, 0,  0, 1, 16'h0000, 1));
    tbl.push_back(mk(1, 0, 0,   16'h0,    1, 1,   0, 1,  1, 1, 16'h2222, 0));
    tbl.push_back(mk(1, 0, 0,   16'h0,    1, 255, 0, 1,  1, 1, 16'h0000, 1));
    tbl.push_back(mk(1, 0, 0,   16'h0,    0, 0,   0, 1,  1, 0, 16'h0000, 0)); // drain clears fault
    tbl.push_back(mk(1, 1, 199, 16'h7777, 1, 199, 0, 1,  0, 0, 16'h0000, 0)); // last word
    tbl.push_back(mk(1, 0, 0,   16'h0,    1, 199, 0, 1,  1, 1, 16'h7777, 0));
    tbl.push_back(mk(1, 0, 0,   16'h0,    1, 200, 0, 1,  1, 1, 16'h0000, 1)); // first bad
    tbl.push_back(mk(1, 1, 1,   16'hABCD, 1, 1,   0, 1,  0, 0, 16'h0000, 0)); // load priority
    tbl.push_back(mk(1, 0, 0,   16'h0,    1, 1,   0, 1,  1, 1, 16'hABCD, 0)); // RAW
    tbl.push_back(mk(1, 1, 1,   16'h5555, 0, 0,   0, 0,  0, 1, 16'hABCD, 0)); // held word untouched
    tbl.push_back(mk(1, 0, 0,   16'h0,    1, 1,   0, 1,  1, 1, 16'h5555, 0));
    tbl.push_back(mk(1, 0, 0,   16'h0,    1, 2,   0, 1,  1, 1, 16'h3333, 0));
    tbl.push_back(mk(1, 0, 0,   16'h0,    1, 0,   1, 0,  0, 0, 16'h0000, 0)); // flush while held
    tbl.push_back(mk(1, 0, 0,   16'h0,    1, 3,   1, 1,  1, 0, 16'h0000, 0)); // flush drops accept
    tbl.push_back(mk(1, 0, 0,   16'h0,    1, 0,   0, 1,  1, 1, 16'h1111, 0));
    tbl.push_back(mk(1, 0, 0,   16'h0,    1, 2,   1, 1,  1, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 0, 0,   16'h0,    1, 2,   0, 0,  1, 1, 16'h3333, 0));

    foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i]);

    // Reset mid-operation: held word discarded, memory retained.
    step("rst_mid",   mk(0, 0, 0, 16'h0, 1, 3,   0, 1,  0, 0, 16'h0000, 0));
    step("rst_fetch", mk(1, 0, 0, 16'h0, 1, 0,   0, 1,  1, 1, 16'h1111, 0));
    // Reset while a fault is held.
    step("flt_set",   mk(1, 0, 0, 16'h0, 1, 220, 0, 1,  1, 1, 16'h0000, 1));
    step("flt_rst",   mk(0, 0, 0, 16'h0, 0, 0,   0, 0,  0, 0, 16'h0000, 0));
    step("flt_after", mk(1, 0, 0, 16'h0, 1, 3,   0, 0,  1, 1, 16'h4444, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_mem_fetch.md
Name: instr_mem_fetch

Overview:
- Parametrised instruction memory for the RISC core; next generation of the plain address-in/instruction-out instruction memory.
- Adds a program-load write port, a valid/ready fetch handshake with a registered 1-cycle read, and output hold under back-pressure.
- Also adds flush for branch redirects and address-fault flagging.
- Sits between the PC/fetch stage and the decode stage.

Parameters:
- DATA_WIDTH, 16, instruction word width in bits.
- ADDR_WIDTH, 8, fetch/load address width in bits (word addressed).
- DEPTH, 256, number of implemented words; must satisfy DEPTH <= 2**ADDR_WIDTH.
- NOP_WORD, 16'h0000, value driven on Instruction at reset, on flush, and on fault.

Ports:
- Clk  input  1  rising-edge clock.
- Reset_n  input  1  synchronous, active-low reset.
- Load_en  input  1  write Load_data to Load_addr this cycle.
- Load_addr  input  ADDR_WIDTH  load write address.
- Load_data  input  DATA_WIDTH  load write data.
- Req_valid  input  1  fetch request present.
- Address  input  ADDR_WIDTH  fetch address.
- Req_ready  output  1  fetch request can be accepted this cycle.
- Flush  input  1  discard the held and in-flight instruction.
- Instruction  output  DATA_WIDTH  fetched instruction word.
- Instr_valid  output  1  Instruction is valid.
- Instr_ready  input  1  decode stage consumes Instruction.
- Addr_fault  output  1  the current valid output came from Address >= DEPTH.

Behaviour:
- Clock and reset: one clock, Clk. Reset_n is synchronous and active-low.
- Reset values (Reset_n=0 at a rising edge):
  - Instr_valid=0, Addr_fault=0, Instruction=NOP_WORD, state=EMPTY.
  - Memory contents are not reset.
  - Req_ready is combinational; it is 0 while Reset_n=0.
- Memory: DEPTH x DATA_WIDTH array.
  - A write occurs at the rising edge when Load_en=1 and Load_addr < DEPTH.
  - A load to Load_addr >= DEPTH is silently dropped.
- Req_ready = Reset_n & !Load_en & (!Instr_valid | Instr_ready).
  - Load has priority: no fetch is accepted in a cycle with Load_en=1.
- Accept: Req_valid & Req_ready at edge N.
  - At N, Instruction is loaded with mem[Address], or NOP_WORD with Addr_fault=1 if Address >= DEPTH.
  - Instr_valid=1 from N+1. Latency is exactly 1 cycle.
- Read-after-write: a fetch accepted the cycle after a load to the same address returns the new data. There is no same-cycle bypass, because load and fetch are never simultaneous.
- Hold: while Instr_valid=1 and Instr_ready=0, Instruction, Addr_fault and Instr_valid stay stable. Req_ready=0 in this case.
- Drain and refill: Instr_valid & Instr_ready & an accepted request in the same cycle gives a new word next cycle with no bubble. This sustains 1 instruction/cycle.
- Drain only: Instr_valid & Instr_ready with no accept gives Instr_valid=0 and Addr_fault=0 next cycle. Instruction keeps its last value.
- Flush=1 at edge:
  - Instr_valid=0, Addr_fault=0, Instruction=NOP_WORD. Flush overrides any accept in the same cycle, so that request is dropped.
  - The requester must re-present the request after the flush; Req_ready is not gated by Flush.
- States: EMPTY (Instr_valid=0) and FULL (Instr_valid=1).
  - EMPTY -> FULL on accept.
  - FULL -> FULL on (Instr_ready & accept) or !Instr_ready.
  - FULL -> EMPTY on Instr_ready & !accept.
  - Any state -> EMPTY on Flush or reset.
  - Load_en does not change state, and the held word is not updated by a load to its address.
- Reset mid-operation: any held word is discarded; the first cycle after reset has Instr_valid=0.
- Width rules: addresses compare unsigned against DEPTH. When DEPTH == 2**ADDR_WIDTH, Addr_fault can never assert.

Test Plan:
- Load then fetch:
  - Stimulus: load mem[0..3]=16'h1111, 2222, 3333, 4444. Then Req_valid=1 with Address 0,1,2,3 on consecutive cycles, Instr_ready=1.
  - Required response: Instr_valid high from the cycle after the first accept; Instruction = 1111, 2222, 3333, 4444 one per cycle, no bubbles, Addr_fault=0.
- Back-pressure:
  - Stimulus: fetch addr 2 (16'h3333), then hold Instr_ready=0 for 3 cycles with Req_valid=1 and Address=3.
  - Required response: Req_ready=0, Instruction stays 3333 and Instr_valid stays 1 throughout. After Instr_ready=1, 4444 appears the next cycle.
- Fault:
  - Stimulus: DEPTH=200, ADDR_WIDTH=8, fetch Address=8'd210.
  - Required response: next cycle Instr_valid=1, Addr_fault=1, Instruction=NOP_WORD. Then fetch Address=1: Addr_fault=0, Instruction=2222.
- Load priority and read-after-write:
  - Stimulus: Load_en=1 with Load_addr=1, Load_data=16'hABCD, while Req_valid=1 and Address=1.
  - Required response: Req_ready=0 that cycle. The next cycle's accept returns ABCD.
- Flush:
  - Stimulus: Instr_valid=1 holding 16'h3333 with Instr_ready=0; assert Flush together with a Req_valid for Address 0.
  - Required response: next cycle Instr_valid=0 and Instruction=NOP_WORD; the request is dropped. Re-issuing Address 0 returns 1111.
- Reset mid-operation:
  - Stimulus: Reset_n=0 for 1 cycle while Instr_valid=1.
  - Required response: next cycle Instr_valid=0, Addr_fault=0, Instruction=NOP_WORD, and Req_ready=0 during reset. Memory contents are retained, so fetching addr 0 afterwards returns 1111.
